// File: rtl/debug_csr_unit.sv
// Debug/performance CSR block: cycle/instr/event counters, single-step, PC breakpoints and
// scratch registers on two Avalon-MM slaves (s1 = CPU, s2 = JTAG), driving a registered halt.
module debug_csr_unit #(
   parameter int ADDR_W    = 8,
   parameter int N_EVENTS  = 4,
   parameter int N_BKPT    = 2,
   parameter int N_SCRATCH = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_EVENTS-1:0] ev_inc,
   input  logic                wb_valid,
   input  logic [31:0]         wb_pc,
   output logic                halt_cpu,
   input  logic [ADDR_W-1:0]   s1_address,
   input  logic                s1_read,
   input  logic                s1_write,
   input  logic [31:0]         s1_writedata,
   output logic [31:0]         s1_readdata,
   input  logic [ADDR_W-1:0]   s2_address,
   input  logic                s2_read,
   input  logic                s2_write,
   input  logic [31:0]         s2_writedata,
   output logic [31:0]         s2_readdata
);
   localparam int IDX_W   = ADDR_W - 2;
   localparam int N_WORDS = 1 << IDX_W;

   typedef struct packed {
      logic        en;
      logic [31:0] data;
   } wr_t;

   logic [IDX_W-1:0]  s1_idx, s2_idx;
   logic              unused_addr_lsbs;
   logic              run;
   logic              bkpt_clr;
   logic [N_BKPT-1:0] bkpt_match;
   logic [63:0]       cycle_inc, instr_inc;
   logic [31:0]       csr_word [N_WORDS];

   logic [63:0] cycle_q, cycle_d;
   logic [63:0] instr_q, instr_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] steps_q, steps_d;
   logic        bkpt_hit_q, bkpt_hit_d;
   logic [2:0]  hit_idx_q, hit_idx_d;
   logic        halt_q, halt_d;
   logic [31:0] bkpt_q [N_BKPT];
   logic [31:0] bkpt_d [N_BKPT];
   logic [31:0] evcnt_q [N_EVENTS];
   logic [31:0] evcnt_d [N_EVENTS];
   logic [31:0] scratch_q [N_SCRATCH];
   logic [31:0] scratch_d [N_SCRATCH];
   logic [31:0] s1_readdata_q, s1_readdata_d;
   logic [31:0] s2_readdata_q, s2_readdata_d;

   assign s1_idx           = s1_address[ADDR_W-1:2];
   assign s2_idx           = s2_address[ADDR_W-1:2];
   assign unused_addr_lsbs = ^{s1_address[1:0], s2_address[1:0]};

   // s1 takes priority when both ports write the same word in one cycle
   function automatic wr_t word_wr(input int unsigned w);
      wr_t r;
      if (s1_write && (s1_idx == IDX_W'(w))) begin
         r.en   = 1'b1;
         r.data = s1_writedata;
      end else if (s2_write && (s2_idx == IDX_W'(w))) begin
         r.en   = 1'b1;
         r.data = s2_writedata;
      end else begin
         r.en   = 1'b0;
         r.data = 32'd0;
      end
      return r;
   endfunction

   function automatic logic [31:0] wr_or(input int unsigned w, input logic [31:0] cur);
      wr_t r;
      r = word_wr(w);
      return r.en ? r.data : cur;
   endfunction

   // Counters, control and storage registers: bus writes win over local updates
   always_comb begin
      run       = ~halt_q & ~ctrl_q[3];
      cycle_inc = cycle_q + 64'(run);
      instr_inc = instr_q + 64'(run & wb_valid);
      cycle_d   = {wr_or(32'd1, cycle_inc[63:32]), wr_or(32'd0, cycle_inc[31:0])};
      instr_d   = {wr_or(32'd6, instr_inc[63:32]), wr_or(32'd5, instr_inc[31:0])};
      ctrl_d    = 4'(wr_or(32'd2, {28'd0, ctrl_q}));
      steps_d   = wr_or(32'd3, (ctrl_q[0] && (steps_q != 32'd0) && !halt_q) ?
                               steps_q - 32'd1 : steps_q);
      for (int k = 0; k < N_BKPT; k++) begin
         bkpt_d[k] = wr_or(32'(8 + k), bkpt_q[k]);
      end
      for (int k = 0; k < N_EVENTS; k++) begin
         evcnt_d[k] = wr_or(32'(16 + k), evcnt_q[k] + 32'(run & ev_inc[k]));
      end
      for (int k = 0; k < N_SCRATCH; k++) begin
         scratch_d[k] = wr_or(32'(32 + k), scratch_q[k]);
      end
   end

   // Breakpoint match, sticky hit with set-over-clear, and the halt decision
   always_comb begin
      bkpt_clr  = (wr_or(32'd4, 32'd0) & 32'h0000_0002) != 32'd0;
      hit_idx_d = hit_idx_q;
      for (int k = N_BKPT - 1; k >= 0; k--) begin
         bkpt_match[k] = ctrl_q[2] & wb_valid & ~halt_q & (wb_pc == bkpt_q[k]);
         if (bkpt_match[k]) begin
            hit_idx_d = 3'(k);
         end else begin
            hit_idx_d = hit_idx_d;
         end
      end
      bkpt_hit_d = (|bkpt_match) | (bkpt_hit_q & ~bkpt_clr);
      halt_d     = ctrl_d[1] | bkpt_hit_d | (ctrl_d[0] & (steps_d == 32'd0));
   end

   // Word-indexed view of the register file; unmapped words read 0
   always_comb begin
      for (int w = 0; w < N_WORDS; w++) begin
         csr_word[w] = 32'd0;
      end
      csr_word[0] = cycle_q[31:0];
      csr_word[1] = cycle_q[63:32];
      csr_word[2] = {28'd0, ctrl_q};
      csr_word[3] = steps_q;
      csr_word[4] = {21'd0, hit_idx_q, 6'd0, bkpt_hit_q, halt_q};
      csr_word[5] = instr_q[31:0];
      csr_word[6] = instr_q[63:32];
      for (int k = 0; k < N_BKPT; k++) begin
         csr_word[8 + k] = bkpt_q[k];
      end
      for (int k = 0; k < N_EVENTS; k++) begin
         csr_word[16 + k] = evcnt_q[k];
      end
      for (int k = 0; k < N_SCRATCH; k++) begin
         csr_word[32 + k] = scratch_q[k];
      end
   end

   // Read data captures pre-write register state and holds until the next read
   always_comb begin
      s1_readdata_d = s1_read ? csr_word[s1_idx] : s1_readdata_q;
      s2_readdata_d = s2_read ? csr_word[s2_idx] : s2_readdata_q;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_q       <= 64'd0;
         instr_q       <= 64'd0;
         ctrl_q        <= 4'd0;
         steps_q       <= 32'd0;
         bkpt_hit_q    <= 1'b0;
         hit_idx_q     <= 3'd0;
         halt_q        <= 1'b0;
         s1_readdata_q <= 32'd0;
         s2_readdata_q <= 32'd0;
         for (int k = 0; k < N_BKPT; k++) begin
            bkpt_q[k] <= 32'd0;
         end
         for (int k = 0; k < N_EVENTS; k++) begin
            evcnt_q[k] <= 32'd0;
         end
         for (int k = 0; k < N_SCRATCH; k++) begin
            scratch_q[k] <= 32'd0;
         end
      end else begin
         cycle_q       <= cycle_d;
         instr_q       <= instr_d;
         ctrl_q        <= ctrl_d;
         steps_q       <= steps_d;
         bkpt_hit_q    <= bkpt_hit_d;
         hit_idx_q     <= hit_idx_d;
         halt_q        <= halt_d;
         s1_readdata_q <= s1_readdata_d;
         s2_readdata_q <= s2_readdata_d;
         bkpt_q        <= bkpt_d;
         evcnt_q       <= evcnt_d;
         scratch_q     <= scratch_d;
      end
   end

   assign halt_cpu    = halt_q;
   assign s1_readdata = s1_readdata_q;
   assign s2_readdata = s2_readdata_q;

endmodule
